// File: rtl/ped_xing_ctrl.sv
// ped_xing_ctrl: pedestrian-crossing controller with debounced request buttons, tick prescaler,
// programmable phase durations, all-red clearance, flashing walk and a BCD walk countdown.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   button          raw asynchronous request buttons, active-high, OR-combined after debounce
//   led             traffic lamps {red,yellow,green}
//   walk/dont_walk  pedestrian lamps
//   req_pending     a crossing request is latched and not yet served
//   countdown       BCD {tens,units} ticks left in the crossing, count_valid marks it meaningful
//   state_dbg       encoded controller state
module ped_xing_ctrl #(
    parameter int N_BTN          = 2,
    parameter int TICK_DIV       = 4,
    parameter int DEB_CYC        = 3,
    parameter int T_YELLOW       = 2,
    parameter int T_CLEAR        = 1,
    parameter int T_WALK         = 5,
    parameter int T_FLASH        = 3,
    parameter int T_RELAX        = 6,
    parameter bit LATCH_IN_RELAX = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] button,
    output logic [2:0]       led,
    output logic             walk,
    output logic             dont_walk,
    output logic             req_pending,
    output logic [7:0]       countdown,
    output logic             count_valid,
    output logic [2:0]       state_dbg
);
    typedef enum logic [2:0] {
        GREEN  = 3'd0,
        YELLOW = 3'd1,
        CLEAR  = 3'd2,
        WALK   = 3'd3,
        FLASH  = 3'd4,
        RELAX  = 3'd5
    } state_t;
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int TCW = 16;
    localparam logic [7:0] CD_INIT = {4'((T_WALK + T_FLASH) / 10), 4'((T_WALK + T_FLASH) % 10)};
    localparam logic FL_PAR = 1'(T_FLASH % 2);
    state_t           state_q, state_d;
    logic [N_BTN-1:0] sync1_q, sync2_q, lvl_q, lvl_d;
    logic [DW-1:0]    cnt_q [N_BTN];
    logic [DW-1:0]    cnt_d [N_BTN];
    logic             any_q;
    logic [PW-1:0]    pre_q, pre_d;
    logic [TCW-1:0]   tcnt_q, tcnt_d;
    logic [7:0]       cd_q, cd_d, cd_dec;
    logic             req_q, req_d;
    logic [2:0]       led_q, led_d;
    logic             walk_q, walk_d, dw_q, dw_d, cv_q, cv_d;
    logic             ev, accept, tick, done, entry, xing_d;

    function automatic logic [TCW-1:0] load(state_t s);
        return (s == YELLOW) ? TCW'(T_YELLOW - 1) :
               (s == CLEAR)  ? TCW'(T_CLEAR - 1)  :
               (s == WALK)   ? TCW'(T_WALK - 1)   :
               (s == FLASH)  ? TCW'(T_FLASH - 1)  :
               (s == RELAX)  ? TCW'(T_RELAX - 1)  : '0;
    endfunction

    // Debounce: count consecutive synchronised-high samples; level drops on the first low sample.
    always_comb begin
        lvl_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = !sync2_q[i] ? '0 : (cnt_q[i] == DW'(DEB_CYC)) ? cnt_q[i] : cnt_q[i] + 1'b1;
            lvl_d[i] = sync2_q[i] && (cnt_q[i] >= DW'(DEB_CYC - 1));
        end
    end

    always_comb begin
        ev     = (|lvl_q) && !any_q;
        tick   = pre_q == PW'(TICK_DIV - 1);
        done   = tick && (tcnt_q == '0);
        state_d = state_q;
        case (state_q)
            GREEN:   if (req_q) state_d = YELLOW;
            YELLOW:  if (done) state_d = CLEAR;
            CLEAR:   if (done) state_d = WALK;
            WALK:    if (done) state_d = FLASH;
            FLASH:   if (done) state_d = RELAX;
            RELAX:   if (done) state_d = req_q ? YELLOW : GREEN;
            default: state_d = GREEN;
        endcase
        entry  = state_d != state_q;
        pre_d  = (entry || tick) ? '0 : pre_q + 1'b1;
        tcnt_d = entry ? load(state_d) : tick ? tcnt_q - 1'b1 : tcnt_q;
        accept = ev && ((state_q inside {GREEN, YELLOW, CLEAR}) || (state_q == RELAX && LATCH_IN_RELAX));
        // Entering WALK serves the request; an event in that same cycle is dropped with it.
        req_d  = (state_d == WALK && state_q != WALK) ? 1'b0 : (req_q || accept);
        xing_d = (state_d == WALK) || (state_d == FLASH);
        cd_dec = (cd_q[3:0] == 4'd0) ? {cd_q[7:4] - 4'd1, 4'd9} : {cd_q[7:4], cd_q[3:0] - 4'd1};
        cd_d   = !xing_d ? 8'h00 : (state_q != WALK && state_d == WALK) ? CD_INIT : tick ? cd_dec : cd_q;
        led_d  = (state_d == GREEN || state_d == RELAX) ? 3'b001 : (state_d == YELLOW) ? 3'b010 : 3'b100;
        // In FLASH the countdown parity tracks the tick index: walk is lit on the 1st, 3rd, ... tick.
        walk_d = (state_d == WALK) || (state_d == FLASH && cd_d[0] == FL_PAR);
        dw_d   = !xing_d;
        cv_d   = xing_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
            state_q <= GREEN;
            pre_q   <= '0;
            tcnt_q  <= '0;
            cd_q    <= 8'h00;
            req_q   <= 1'b0;
            led_q   <= 3'b001;
            walk_q  <= 1'b0;
            dw_q    <= 1'b1;
            cv_q    <= 1'b0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            any_q   <= |lvl_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pre_q   <= pre_d;
            tcnt_q  <= tcnt_d;
            cd_q    <= cd_d;
            req_q   <= req_d;
            led_q   <= led_d;
            walk_q  <= walk_d;
            dw_q    <= dw_d;
            cv_q    <= cv_d;
        end
    end

    assign led         = led_q;
    assign walk        = walk_q;
    assign dont_walk   = dw_q;
    assign req_pending = req_q;
    assign countdown   = cd_q;
    assign count_valid = cv_q;
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_ped_xing_ctrl.sv
// tb_ped_xing_ctrl: bench for ped_xing_ctrl with latching (dut0) and non-latching (dut1) relax.
module tb_ped_xing_ctrl;
    localparam int N_BTN = 2, TD = 4, DEB = 3, TY = 2, TC = 1, TW = 5, TF = 3, TR = 6;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N_BTN-1:0] button = '0;
    logic [2:0] led_a, led_b, dbg_a, dbg_b;
    logic walk_a, walk_b, dw_a, dw_b, req_a, req_b, cv_a, cv_b;
    logic [7:0] cd_a, cd_b;
    logic [17:0] act [2];
    int nvec = 0, nbad = 0;
    int mp [2];
    int mel [2];
    bit mreq [2];
    bit [N_BTN-1:0] sq [DEB+4];

    always #5 clk = ~clk;

    ped_xing_ctrl #(.N_BTN(N_BTN), .TICK_DIV(TD), .DEB_CYC(DEB), .T_YELLOW(TY), .T_CLEAR(TC),
        .T_WALK(TW), .T_FLASH(TF), .T_RELAX(TR), .LATCH_IN_RELAX(1'b1)) u_a (
        .clk(clk), .reset(reset), .button(button), .led(led_a), .walk(walk_a), .dont_walk(dw_a),
        .req_pending(req_a), .countdown(cd_a), .count_valid(cv_a), .state_dbg(dbg_a));
    ped_xing_ctrl #(.N_BTN(N_BTN), .TICK_DIV(TD), .DEB_CYC(DEB), .T_YELLOW(TY), .T_CLEAR(TC),
        .T_WALK(TW), .T_FLASH(TF), .T_RELAX(TR), .LATCH_IN_RELAX(1'b0)) u_b (
        .clk(clk), .reset(reset), .button(button), .led(led_b), .walk(walk_b), .dont_walk(dw_b),
        .req_pending(req_b), .countdown(cd_b), .count_valid(cv_b), .state_dbg(dbg_b));

    assign act[0] = {led_a, walk_a, dw_a, req_a, cd_a, cv_a, dbg_a};
    assign act[1] = {led_b, walk_b, dw_b, req_b, cd_b, cv_b, dbg_b};

    // Debounced level as seen o edges ago: DEB consecutive raw samples, two sync stages older.
    function automatic bit lvl_at(int o);
        bit any = 0;
        for (int b = 0; b < N_BTN; b++) begin
            bit all = 1;
            for (int i = o; i < o + DEB; i++) all &= sq[i][b];
            any |= all;
        end
        return any;
    endfunction

    function automatic int dur(int p);
        return (p == 1 ? TY : p == 2 ? TC : p == 3 ? TW : p == 4 ? TF : TR) * TD;
    endfunction

    // Phases numbered 0..5 = GREEN, YELLOW, CLEAR, WALK, FLASH, RELAX; el = cycles spent in phase.
    task automatic model_step();
        if (reset) begin
            for (int i = 0; i < DEB + 4; i++) sq[i] = '0;
            for (int m = 0; m < 2; m++) begin mp[m] = 0; mel[m] = 0; mreq[m] = 0; end
        end else begin
            bit ev;
            for (int i = DEB + 3; i > 0; i--) sq[i] = sq[i-1];
            sq[0] = button;
            ev = lvl_at(3) && !lvl_at(4);
            for (int m = 0; m < 2; m++) begin
                int p = mp[m], np = mp[m];
                bit acc;
                if (p == 0) begin
                    if (mreq[m]) np = 1;
                end else if (mel[m] + 1 == dur(p)) np = (p == 5) ? (mreq[m] ? 1 : 0) : p + 1;
                acc = ev && (p <= 2 || (p == 5 && m == 0));
                mreq[m] = (np == 3 && p != 3) ? 1'b0 : (mreq[m] || acc);
                mel[m] = (np != p) ? 0 : mel[m] + 1;
                mp[m] = np;
            end
        end
    endtask

    function automatic logic [17:0] exp_vec(int m);
        int p = mp[m], e = mel[m], cd = 0;
        bit w = 0, x;
        logic [2:0] led;
        x = (p == 3 || p == 4);
        led = (p == 0 || p == 5) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
        if (p == 3) begin cd = TW + TF - e / TD; w = 1; end
        if (p == 4) begin cd = TF - e / TD; w = ((e / TD) % 2 == 0); end
        return {led, w, ~x, mreq[m], 4'(cd / 10), 4'(cd % 10), x, 3'(p)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        for (int c = 0; c < 50; c++) begin
            cyc();
            for (int m = 0; m < 2; m++) begin
                nvec++;
                if (act[m] !== exp_vec(m)) begin nbad++; $display("FAIL reset_idle dut%0d t=%0t got %h want %h", m, $time, act[m], exp_vec(m)); end
            end
        end
        for (int m = 0; m < 2; m++) begin
            nvec++;
            if (act[m] !== 18'b001_0_1_0_00000000_0_000) begin nbad++; $display("FAIL reset_state dut%0d got %h want %h", m, act[m], 18'b001_0_1_0_00000000_0_000); end
        end
    endtask

    task automatic test_glitch();
        button = 2'b01;
        repeat (2) cyc();
        button = '0;
        for (int c = 0; c < 30; c++) begin
            cyc();
            for (int m = 0; m < 2; m++) begin
                nvec++;
                if (act[m] !== exp_vec(m)) begin nbad++; $display("FAIL glitch dut%0d t=%0t got %h want %h", m, $time, act[m], exp_vec(m)); end
            end
        end
        nvec++;
        if ({req_a, dbg_a} !== 4'b0_000) begin nbad++; $display("FAIL glitch_reject got req=%b st=%0d want req=0 st=0", req_a, dbg_a); end
    endtask

    task automatic test_long_press();
        int cnt [8];
        int walks = 0, fw = 0, first = -1;
        logic [2:0] prev = 3'd0;
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        button = 2'b10;
        for (int c = 0; c < 120; c++) begin
            if (c == 40) button = '0;
            cyc();
            for (int m = 0; m < 2; m++) begin
                nvec++;
                if (act[m] !== exp_vec(m)) begin nbad++; $display("FAIL long_press dut%0d t=%0t got %h want %h", m, $time, act[m], exp_vec(m)); end
            end
            if (req_a && first < 0) first = c;
            cnt[dbg_a]++;
            if (dbg_a == 3'd3 && prev != 3'd3) walks++;
            if (dbg_a == 3'd4 && walk_a) fw++;
            prev = dbg_a;
        end
        nvec++;
        if (first != DEB + 2) begin nbad++; $display("FAIL req_latency got cycle %0d want %0d", first, DEB + 2); end
        nvec++;
        if (cnt[1] != 8) begin nbad++; $display("FAIL yellow_len got %0d want 8", cnt[1]); end
        nvec++;
        if (cnt[2] != 4) begin nbad++; $display("FAIL clear_len got %0d want 4", cnt[2]); end
        nvec++;
        if (cnt[3] != 20) begin nbad++; $display("FAIL walk_len got %0d want 20", cnt[3]); end
        nvec++;
        if (cnt[4] != 12) begin nbad++; $display("FAIL flash_len got %0d want 12", cnt[4]); end
        nvec++;
        if (cnt[5] != 24) begin nbad++; $display("FAIL relax_len got %0d want 24", cnt[5]); end
        nvec++;
        if (walks != 1) begin nbad++; $display("FAIL one_crossing got %0d want 1", walks); end
        nvec++;
        if (fw != 8) begin nbad++; $display("FAIL flash_walk_cycles got %0d want 8", fw); end
        nvec++;
        if (dbg_a !== 3'd0) begin nbad++; $display("FAIL back_to_green got %0d want 0", dbg_a); end
    endtask

    task automatic test_press_in_crossing();
        int targets [3] = '{3, 4, 0};
        button = 2'b01;
        for (int t = 0; t < 3; t++) begin
            for (int c = 0; c < 100 && (c < 10 || dbg_a != 3'(targets[t])); c++) begin
                if (c == 10) button = '0;
                cyc();
                for (int m = 0; m < 2; m++) begin
                    nvec++;
                    if (act[m] !== exp_vec(m)) begin nbad++; $display("FAIL crossing_press dut%0d t=%0t got %h want %h", m, $time, act[m], exp_vec(m)); end
                end
            end
            button = '0;
            nvec++;
            if (dbg_a !== 3'(targets[t])) begin nbad++; $display("FAIL crossing_wait got st=%0d want st=%0d", dbg_a, targets[t]); end
            if (t < 2) begin
                button = 2'b11;
                for (int c = 0; c < 9; c++) cyc();
                button = '0;
                nvec++;
                if (req_a !== 1'b0) begin nbad++; $display("FAIL crossing_discard phase %0d got req=%b want 0", targets[t], req_a); end
            end
        end
        for (int c = 0; c < 10; c++) cyc();
        nvec++;
        if ({req_a, dbg_a} !== 4'b0_000) begin nbad++; $display("FAIL crossing_idle got req=%b st=%0d want req=0 st=0", req_a, dbg_a); end
    endtask

    task automatic test_relax_latch();
        button = 2'b01;
        for (int c = 0; c < 120 && (c < 10 || dbg_a != 3'd5); c++) begin
            if (c == 10) button = '0;
            cyc();
            for (int m = 0; m < 2; m++) begin
                nvec++;
                if (act[m] !== exp_vec(m)) begin nbad++; $display("FAIL relax_run dut%0d t=%0t got %h want %h", m, $time, act[m], exp_vec(m)); end
            end
        end
        nvec++;
        if (dbg_a !== 3'd5) begin nbad++; $display("FAIL relax_wait got st=%0d want 5", dbg_a); end
        button = 2'b10;
        for (int c = 0; c < 10; c++) cyc();
        button = '0;
        nvec++;
        if ({req_a, req_b} !== 2'b10) begin nbad++; $display("FAIL relax_latch got req a/b=%b%b want 10", req_a, req_b); end
        for (int c = 0; c < 40 && dbg_a == 3'd5; c++) cyc();
        nvec++;
        if ({dbg_a, dbg_b} !== {3'd1, 3'd0}) begin nbad++; $display("FAIL relax_exit got st a/b=%0d/%0d want 1/0", dbg_a, dbg_b); end
        for (int c = 0; c < 100; c++) begin
            cyc();
            for (int m = 0; m < 2; m++) begin
                nvec++;
                if (act[m] !== exp_vec(m)) begin nbad++; $display("FAIL relax_serve dut%0d t=%0t got %h want %h", m, $time, act[m], exp_vec(m)); end
            end
        end
    endtask

    task automatic test_mid_walk_reset();
        button = 2'b10;
        for (int c = 0; c < 60 && (c < 10 || dbg_a != 3'd3); c++) begin
            if (c == 10) button = '0;
            cyc();
        end
        button = '0;
        repeat (5) cyc();
        nvec++;
        if ({walk_a, cv_a} !== 2'b11) begin nbad++; $display("FAIL mid_walk_setup got walk=%b cv=%b want 11", walk_a, cv_a); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        nvec++;
        if ({led_a, walk_a, cd_a, cv_a, dbg_a} !== {3'b001, 1'b0, 8'h00, 1'b0, 3'd0}) begin
            nbad++; $display("FAIL mid_walk_reset got led=%b walk=%b cd=%h cv=%b st=%0d want 001 0 00 0 0", led_a, walk_a, cd_a, cv_a, dbg_a);
        end
        for (int c = 0; c < 20; c++) begin
            cyc();
            for (int m = 0; m < 2; m++) begin
                nvec++;
                if (act[m] !== exp_vec(m)) begin nbad++; $display("FAIL after_reset dut%0d t=%0t got %h want %h", m, $time, act[m], exp_vec(m)); end
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                button = ($urandom_range(0, 2) == 0) ? '0 : N_BTN'($urandom);
                hold = $urandom_range(1, 14);
            end
            hold--;
            reset = ($urandom_range(0, 799) == 0);
            cyc();
            for (int m = 0; m < 2; m++) begin
                nvec++;
                if (act[m] !== exp_vec(m)) begin nbad++; $display("FAIL random dut%0d t=%0t got %h want %h", m, $time, act[m], exp_vec(m)); end
            end
        end
        reset = 1'b0;
        button = '0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_long_press();
        test_press_in_crossing();
        test_relax_latch();
        test_mid_walk_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
